// File: rtl/ifu_pkg.sv
// Shared types and AXI constants for the instruction fetch unit.
// Provides the CPU_WIDTH default used by all fetch-unit files.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      OUT  = 2'd3
   } ifu_state_e;

   localparam logic [2:0]            SIZE_4B      = 3'b010;
   localparam logic [1:0]            BURST_INCR   = 2'b01;
   localparam logic [1:0]            RESP_OKAY    = 2'b00;
   localparam logic [`CPU_WIDTH-1:0] IFU_RESET_PC = `CPU_WIDTH'(32'h8000_0000);

   function automatic logic [`CPU_WIDTH-1:0] pc_next(input logic [`CPU_WIDTH-1:0] pc);
      return pc + `CPU_WIDTH'(4);
   endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Wrapping fetch/stall event counters for the fetch unit.
// Only instantiated when IFU_PERF_EN is defined.
module ifu_perf_cnt (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_i,
   input  logic        stall_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
);

   logic [31:0] fetch_q, fetch_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      fetch_d = fetch_q;
      stall_d = stall_q;
      if (fetch_i) fetch_d = fetch_q + 32'd1;
      if (stall_i) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_q <= 32'd0;
         stall_q <= 32'd0;
      end else begin
         fetch_q <= fetch_d;
         stall_q <= stall_d;
      end
   end

   assign fetch_cnt_o = fetch_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: rtl/ifu_axi_fetch.sv
// Single-outstanding AXI4 instruction fetcher feeding a decode handshake.
// Define IFU_PERF_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
//
// state | meaning
// IDLE  | one cycle after reset, redirects update pc directly
// AR    | arvalid held with araddr=pc until arready
// R     | rready high, one beat accepted (discarded if killed)
// OUT   | inst_valid held until inst_ready or redirect
module ifu_axi_fetch #(
   parameter logic [`CPU_WIDTH-1:0] RESET_PC = ifu_pkg::IFU_RESET_PC,
   parameter logic [3:0]            ID       = 4'h0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  ifu_axi_arvalid,
   input  logic                  ifu_axi_arready,
   output logic [`CPU_WIDTH-1:0] ifu_axi_araddr,
   output logic [3:0]            ifu_axi_arid,
   output logic [7:0]            ifu_axi_arlen,
   output logic [2:0]            ifu_axi_arsize,
   output logic [1:0]            ifu_axi_arburst,
   input  logic                  ifu_axi_rvalid,
   output logic                  ifu_axi_rready,
   input  logic [`CPU_WIDTH-1:0] ifu_axi_rdata,
   input  logic [1:0]            ifu_axi_rresp,
   input  logic                  ifu_axi_rlast,
   input  logic [3:0]            ifu_axi_rid,
   output logic                  ifu_axi_awvalid,
   input  logic                  ifu_axi_awready,
   output logic [`CPU_WIDTH-1:0] ifu_axi_awaddr,
   output logic [3:0]            ifu_axi_awid,
   output logic [7:0]            ifu_axi_awlen,
   output logic [2:0]            ifu_axi_awsize,
   output logic [1:0]            ifu_axi_awburst,
   output logic                  ifu_axi_wvalid,
   input  logic                  ifu_axi_wready,
   output logic [`CPU_WIDTH-1:0] ifu_axi_wdata,
   output logic [3:0]            ifu_axi_wstrb,
   output logic                  ifu_axi_wlast,
   input  logic                  ifu_axi_bvalid,
   output logic                  ifu_axi_bready,
   input  logic [1:0]            ifu_axi_bresp,
   input  logic [3:0]            ifu_axi_bid,
   input  logic                  redirect_valid,
   input  logic [`CPU_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [`CPU_WIDTH-1:0] inst,
   output logic [`CPU_WIDTH-1:0] inst_pc,
   output logic                  inst_err
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   import ifu_pkg::*;

   ifu_state_e state_q, state_d;
   logic [`CPU_WIDTH-1:0] pc_q, pc_d;
   logic [`CPU_WIDTH-1:0] inst_q, inst_d;
   logic [`CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic [`CPU_WIDTH-1:0] kill_pc_q, kill_pc_d;
   logic                  inst_err_q, inst_err_d;
   logic                  kill_q, kill_d;
   logic                  beat_err;

   // Bad response, foreign id or a non-last beat all mark the instruction as faulty.
   assign beat_err = (ifu_axi_rresp != RESP_OKAY) || (ifu_axi_rid != ID) || !ifu_axi_rlast;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      inst_d          = inst_q;
      inst_pc_d       = inst_pc_q;
      inst_err_d      = inst_err_q;
      kill_d          = kill_q;
      kill_pc_d       = kill_pc_q;
      ifu_axi_arvalid = 1'b0;
      ifu_axi_rready  = 1'b0;
      inst_valid      = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = AR;
            if (redirect_valid) pc_d = redirect_pc;
         end
         AR: begin
            // araddr must stay put, so a redirect here is parked until the beat returns.
            ifu_axi_arvalid = 1'b1;
            if (redirect_valid) begin
               kill_d    = 1'b1;
               kill_pc_d = redirect_pc;
            end
            if (ifu_axi_arready) state_d = R;
         end
         R: begin
            ifu_axi_rready = 1'b1;
            if (ifu_axi_rvalid) begin
               if (redirect_valid || kill_q) begin
                  pc_d    = redirect_valid ? redirect_pc : kill_pc_q;
                  kill_d  = 1'b0;
                  state_d = AR;
               end else begin
                  inst_d     = ifu_axi_rdata;
                  inst_pc_d  = pc_q;
                  inst_err_d = beat_err;
                  state_d    = OUT;
               end
            end else if (redirect_valid) begin
               kill_d    = 1'b1;
               kill_pc_d = redirect_pc;
            end
         end
         OUT: begin
            inst_valid = 1'b1;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = AR;
            end else if (inst_ready) begin
               pc_d    = pc_next(pc_q);
               state_d = AR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_err_q <= 1'b0;
         kill_q     <= 1'b0;
         kill_pc_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         inst_err_q <= inst_err_d;
         kill_q     <= kill_d;
         kill_pc_q  <= kill_pc_d;
      end
   end

   assign ifu_axi_araddr  = pc_q;
   assign ifu_axi_arid    = ID;
   assign ifu_axi_arlen   = 8'd0;
   assign ifu_axi_arsize  = SIZE_4B;
   assign ifu_axi_arburst = BURST_INCR;

   assign ifu_axi_awvalid = 1'b0;
   assign ifu_axi_awaddr  = '0;
   assign ifu_axi_awid    = 4'd0;
   assign ifu_axi_awlen   = 8'd0;
   assign ifu_axi_awsize  = 3'd0;
   assign ifu_axi_awburst = 2'd0;
   assign ifu_axi_wvalid  = 1'b0;
   assign ifu_axi_wdata   = '0;
   assign ifu_axi_wstrb   = 4'd0;
   assign ifu_axi_wlast   = 1'b0;
   assign ifu_axi_bready  = 1'b0;

   logic unused_wr_chan;
   assign unused_wr_chan = ^{ifu_axi_awready, ifu_axi_wready, ifu_axi_bvalid,
                             ifu_axi_bresp, ifu_axi_bid};

   assign inst     = inst_q;
   assign inst_pc  = inst_pc_q;
   assign inst_err = inst_err_q;

`ifdef IFU_PERF_EN
   logic perf_fetch;
   logic perf_stall;
   assign perf_fetch = inst_valid && inst_ready;
   assign perf_stall = (state_q == AR) || (state_q == R);

   ifu_perf_cnt u_perf (
      .clock       (clock),
      .reset       (reset),
      .fetch_i     (perf_fetch),
      .stall_i     (perf_stall),
      .fetch_cnt_o (perf_fetch_cnt),
      .stall_cnt_o (perf_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch with a small AXI read slave (mem[j]=j).
// Build with IFU_PERF_EN defined to also exercise the perf counters.
module tb_ifu_axi_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  awid, wstrb, bid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, bresp;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready, inst_err;
   logic [31:0] inst, inst_pc;
`ifdef IFU_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int ar_delay   = 0;
   int ar_wait    = 0;
   int ar_hs_cnt  = 0;
   int fault_once = 0;
   logic        prev_arv, prev_arr, prev_rv, prev_rr;
   logic [31:0] prev_addr;

   logic [31:0] hs_inst[$];
   logic [31:0] hs_pc[$];
   logic [31:0] hs_err[$];
   int          hs_cyc[$];

   always #5 clock = ~clock;

   ifu_axi_fetch #(.RESET_PC(RST_PC), .ID(4'h0)) dut (
      .clock(clock), .reset(reset),
      .ifu_axi_arvalid(arvalid), .ifu_axi_arready(arready), .ifu_axi_araddr(araddr),
      .ifu_axi_arid(arid), .ifu_axi_arlen(arlen), .ifu_axi_arsize(arsize),
      .ifu_axi_arburst(arburst),
      .ifu_axi_rvalid(rvalid), .ifu_axi_rready(rready), .ifu_axi_rdata(rdata),
      .ifu_axi_rresp(rresp), .ifu_axi_rlast(rlast), .ifu_axi_rid(rid),
      .ifu_axi_awvalid(awvalid), .ifu_axi_awready(awready), .ifu_axi_awaddr(awaddr),
      .ifu_axi_awid(awid), .ifu_axi_awlen(awlen), .ifu_axi_awsize(awsize),
      .ifu_axi_awburst(awburst),
      .ifu_axi_wvalid(wvalid), .ifu_axi_wready(wready), .ifu_axi_wdata(wdata),
      .ifu_axi_wstrb(wstrb), .ifu_axi_wlast(wlast),
      .ifu_axi_bvalid(bvalid), .ifu_axi_bready(bready), .ifu_axi_bresp(bresp),
      .ifu_axi_bid(bid),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_err(inst_err)
`ifdef IFU_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always @(posedge clock) cyc <= cyc + 1;

   // Read slave: drives at negedge, infers last edge's handshakes from what it saw.
   always @(negedge clock) begin
      if (reset) begin
         arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = 4'h0; rlast = 1'b0;
         ar_wait = 0; ar_hs_cnt = 0;
         prev_arv = 1'b0; prev_arr = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; prev_addr = '0;
      end else begin
         if (prev_rv && prev_rr) rvalid = 1'b0;
         if (prev_arv && prev_arr) begin
            ar_hs_cnt++;
            rvalid = 1'b1;
            rdata  = {22'h0, prev_addr[11:2]};
            rresp  = 2'b00;
            rid    = 4'h0;
            rlast  = 1'b1;
            case (fault_once)
               1: rresp = 2'b10;
               2: rid   = 4'h5;
               3: rlast = 1'b0;
               default: ;
            endcase
            fault_once = 0;
         end
         if (arvalid) begin
            if (ar_wait >= ar_delay) arready = 1'b1;
            else begin
               arready = 1'b0;
               ar_wait++;
            end
         end else begin
            arready = 1'b0;
            ar_wait = 0;
         end
         prev_arv = arvalid; prev_arr = arready; prev_addr = araddr;
         prev_rv = rvalid; prev_rr = rready;
      end
   end

   always @(negedge clock) begin
      if (!reset && inst_valid && inst_ready) begin
         hs_inst.push_back(inst);
         hs_pc.push_back(inst_pc);
         hs_err.push_back({31'h0, inst_err});
         hs_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_hs(input string tag, input int idx, input logic [31:0] e_inst,
                           input logic [31:0] e_pc, input logic [31:0] e_err);
      if (idx < hs_pc.size()) begin
         check({tag, "_inst"}, hs_inst[idx], e_inst);
         check({tag, "_pc"},   hs_pc[idx],   e_pc);
         check({tag, "_err"},  hs_err[idx],  e_err);
      end else begin
         check({tag, "_missing"}, hs_pc.size(), idx + 1);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      ar_delay = 0; fault_once = 0;
      repeat (3) @(posedge clock);
      hs_inst.delete(); hs_pc.delete(); hs_err.delete(); hs_cyc.delete();
      #1 reset = 1'b0;
   endtask

   task automatic wait_hs(input int n, input int budget);
      int k = 0;
      while (hs_pc.size() < n && k < budget) begin
         @(posedge clock);
         k++;
      end
      if (hs_pc.size() < n) check("wait_hs_timeout", hs_pc.size(), n);
   endtask

   // sel: 0 arvalid, 1 rready, 2 inst_valid; returns #1 after a posedge with it high
   task automatic wait_out(input int sel);
      int k = 0;
      logic s;
      s = 1'b0;
      while (k < 50) begin
         s = (sel == 0) ? arvalid : (sel == 1) ? rready : inst_valid;
         if (s) break;
         @(posedge clock); #1;
         k++;
      end
      if (!s) check("wait_out_timeout", sel, 32'hFFFF_FFFF);
   endtask

   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

      // reset values
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_inst_err", inst_err, 0);
      check("rst_wr_chan", {awvalid, wvalid, bready}, 0);

      // zero-wait stream
      do_reset();
      inst_ready = 1'b1;
      @(negedge clock);
      check("idle_arvalid", arvalid, 0);
      @(negedge clock);
      check("ar_arvalid", arvalid, 1);
      check("ar_araddr", araddr, RST_PC);
      check("ar_fields", {arid, arlen, arsize, arburst}, {4'h0, 8'h00, 3'b010, 2'b01});
      wait_hs(3, 30);
      for (int i = 0; i < 3; i++) check_hs("stream", i, i, RST_PC + 4 * i, 0);
      if (hs_cyc.size() >= 3) begin
         check("stream_gap01", hs_cyc[1] - hs_cyc[0], 3);
         check("stream_gap12", hs_cyc[2] - hs_cyc[1], 3);
      end

      // arready held off for 5 cycles
      do_reset();
      inst_ready = 1'b1; ar_delay = 5;
      wait_out(0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock); #1;
         check("arhold_valid", arvalid, 1);
         check("arhold_addr", araddr, RST_PC);
         check("arhold_ready", arready, 0);
      end
      wait_hs(1, 30);
      check_hs("arhold", 0, 0, RST_PC, 0);
      check("arhold_single_hs", ar_hs_cnt, 1);

      // redirect while in R
      do_reset();
      inst_ready = 1'b1;
      wait_out(1);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      wait_hs(2, 40);
      check_hs("redir_r0", 0, 32'h10, 32'h8000_0040, 0);
      check_hs("redir_r1", 1, 32'h11, 32'h8000_0044, 0);

      // error beats: bad rresp, bad rid, missing rlast
      for (int m = 1; m <= 3; m++) begin
         do_reset();
         inst_ready = 1'b1; fault_once = m;
         wait_hs(2, 40);
         check_hs("fault_beat", 0, 0, RST_PC, 1);
         check_hs("fault_next", 1, 1, RST_PC + 4, 0);
      end

      // decode back-pressure in OUT
      do_reset();
      inst_ready = 1'b0;
      wait_out(2);
      for (int c = 0; c < 4; c++) begin
         @(negedge clock); #1;
         check("out_hold_valid", inst_valid, 1);
         check("out_hold_inst", inst, 0);
         check("out_hold_pc", inst_pc, RST_PC);
         check("out_hold_noar", arvalid, 0);
      end
      check("out_hold_ar_cnt", ar_hs_cnt, 1);
      @(posedge clock); #1;
      inst_ready = 1'b1;
      wait_hs(1, 10);
      check_hs("out_release", 0, 0, RST_PC, 0);
      @(negedge clock); #1;
      check("out_next_arvalid", arvalid, 1);
      check("out_next_araddr", araddr, RST_PC + 4);

      // redirect coinciding with decode handshake
      do_reset();
      inst_ready = 1'b1;
      wait_out(2);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      check("redir_out_drop", inst_valid, 0);
      wait_hs(2, 40);
      check_hs("redir_out0", 0, 0, RST_PC, 0);
      check_hs("redir_out1", 1, 32'h40, 32'h8000_0100, 0);

      // redirect during a stalled AR is parked, address held
      do_reset();
      inst_ready = 1'b1; ar_delay = 3;
      wait_out(0);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      @(negedge clock); #1;
      check("redir_ar_valid", arvalid, 1);
      check("redir_ar_addr", araddr, RST_PC);
      wait_hs(1, 40);
      check_hs("redir_ar", 0, 32'h80, 32'h8000_0200, 0);
      check("redir_ar_hs_cnt", ar_hs_cnt, 2);

`ifdef IFU_PERF_EN
      do_reset();
      check("perf_rst_fetch", perf_fetch_cnt, 0);
      check("perf_rst_stall", perf_stall_cnt, 0);
      inst_ready = 1'b1; ar_delay = 2;
      wait_hs(10, 200);
      #1;
      check("perf_fetch", perf_fetch_cnt, 10);
      check("perf_stall", perf_stall_cnt, 40);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ifu_axi_fetch.md
IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter ID, default 4'h0, the constant driven on arid.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports for AR: ifu_axi_arvalid out 1, ifu_axi_arready in 1, ifu_axi_araddr out `CPU_WIDTH, ifu_axi_arid out 4, ifu_axi_arlen out 8, ifu_axi_arsize out 3, ifu_axi_arburst out 2.
REQ-006 SHALL have ports for R: ifu_axi_rvalid in 1, ifu_axi_rready out 1, ifu_axi_rdata in `CPU_WIDTH, ifu_axi_rresp in 2, ifu_axi_rlast in 1, ifu_axi_rid in 4.
REQ-007 SHALL have ports for AW/W/B matching the downstream cache: awvalid, wvalid and bready tied 0; all other AW/W outputs tied 0.
REQ-008 SHALL have port redirect_valid, input, 1, a control-flow change request.
REQ-009 SHALL have port redirect_pc, input, `CPU_WIDTH, the new fetch address, word aligned.
REQ-010 SHALL have ports inst_valid out 1, inst_ready in 1, inst out `CPU_WIDTH, inst_pc out `CPU_WIDTH, inst_err out 1, forming the decode-side handshake.

Function
REQ-011 SHALL implement the FSM states IDLE, AR, R, OUT; from IDLE go to AR the cycle after reset deasserts.
REQ-012 In AR, SHALL hold arvalid=1 with araddr=pc, arlen=0, arsize=3'b010, arburst=2'b01 stable until arready; on handshake go to R.
REQ-013 In R, SHALL drive rready=1; on rvalid&rlast latch rdata into inst and (rresp!=2'b00) into inst_err, then go to OUT.
REQ-014 In OUT, SHALL hold inst_valid=1 with inst/inst_pc/inst_err stable until inst_ready; on handshake set pc<=pc+4 (mod 2^32) and go to AR in the same cycle.
REQ-015 Minimum latency SHALL be 1 cycle AR handshake + 1 cycle R beat + 1 cycle OUT, i.e. 3 cycles per instruction with zero-wait slave and ready decode.
REQ-016 SHALL NOT drop arvalid before arready, even when a redirect arrives in AR; the redirect is recorded as pending.
REQ-017 A redirect in R (or pending from AR) SHALL set pc<=redirect_pc and mark the in-flight beat killed; the beat is still accepted (rready=1) but discarded, then go to AR.
REQ-018 A redirect in OUT SHALL drop inst_valid next cycle, set pc<=redirect_pc and go to AR; if inst_ready coincides, the handshake completes and the redirect wins for pc.
REQ-019 A redirect in IDLE or in the cycle the AR handshake completes SHALL update pc or mark kill respectively; the latest redirect before a beat is accepted takes precedence.
REQ-020 SHALL accept rvalid with rid!=ID or rlast=0 as protocol error: set inst_err=1 on the delivered instruction.

Reset
REQ-021 On reset SHALL set state=IDLE, pc=RESET_PC, arvalid=0, rready=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0, kill=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it with no further AXI activity; the slave is reset by the same signal.

Configuration
REQ-023 With IFU_PERF_EN defined, SHALL add outputs perf_fetch_cnt (32) counting inst handshakes and perf_stall_cnt (32) counting cycles in AR or R, both reset to 0 and wrapping; without it, neither port nor counter exists.

Structure
REQ-024 SHALL place the state enum, AXI constants (SIZE_4B, BURST_INCR, RESP_OKAY) and RESET_PC default in shared package ifu_pkg.
REQ-025 Perf counters SHALL live in sub-module ifu_perf_cnt, instantiated only under IFU_PERF_EN.

Verification
REQ-026 Reset release, zero-wait cache over axi_ram (mem[j]=j) -> inst=0x0,0x1,0x2 at inst_pc=RESET_PC,+4,+8, one every 3 cycles.
REQ-027 arready held low 5 cycles -> arvalid and araddr stable all 5 cycles, a single AR handshake.
REQ-028 redirect_pc=0x8000_0040 while in R -> old beat discarded, next inst_pc=0x8000_0040, no inst_valid for the killed fetch.
REQ-029 rresp=2'b10 on a beat -> inst_valid with inst_err=1 and inst_pc unchanged.
REQ-030 inst_ready low 4 cycles in OUT -> inst/inst_pc stable, no new AR issued until handshake.
REQ-031 IFU_PERF_EN build, 10 fetches with 2-cycle arready delay -> perf_fetch_cnt=10, perf_stall_cnt=40.
